// File: rtl/net_pkg.sv
// net_sync shared types: player record, packet types, TX states, packers.
// Board sync (NET_BOARD_SYNC_EN) uses CELLS_PER_PKT / CHUNK_W from here.
package net_pkg;

    typedef struct packed {
        logic [1:0] dir;
        logic [8:0] x;
        logic [8:0] y;
        logic [3:0] state;
    } player_rec_t;

    localparam logic [2:0] PKT_PLAYER = 3'b000;
    localparam logic [2:0] PKT_BOARD  = 3'b001;
    localparam logic [2:0] PKT_ACK    = 3'b111;

    localparam int CELLS_PER_PKT = 5;
    localparam int CHUNK_BITS    = CELLS_PER_PKT * 4;
    localparam int CHUNK_W       = 7;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SEND,
        TX_WAIT_ACK,
        TX_DROP
    } tx_state_t;

    function automatic logic [31:0] pack_player(
        input logic [1:0]  id,
        input player_rec_t rec,
        input logic [2:0]  gstate
    );
        return {id, rec, gstate, PKT_PLAYER};
    endfunction

    // cells is in wire order: cell 0 in the top nibble
    function automatic logic [31:0] pack_board(
        input logic [1:0]         id,
        input logic [CHUNK_W-1:0] chunk,
        input logic [19:0]        cells
    );
        return {id, chunk, cells, PKT_BOARD};
    endfunction

endpackage

// File: rtl/net_sync_if.sv
// Serial link bundle between net_sync (master) and the serial_tx/rx pair.
// Used identically with or without NET_BOARD_SYNC_EN.
interface net_sync_if;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        tx_ready;
    logic [31:0] tx_data;
    logic        tx_trigger;

    modport master (
        input  rx_data, rx_valid, tx_ready,
        output tx_data, tx_trigger
    );

    modport slave (
        output rx_data, rx_valid, tx_ready,
        input  tx_data, tx_trigger
    );
endinterface

// File: rtl/net_sync_picker.sv
// dirty_chunk_picker: lowest dirty grid chunk at/after ptr, else lowest overall.
// Instantiated by net_sync only when NET_BOARD_SYNC_EN is defined.
module dirty_chunk_picker
    import net_pkg::*;
#(
    parameter int NUM_CHUNKS = 21
) (
    input  logic [NUM_CHUNKS*CHUNK_BITS-1:0] local_grid,
    input  logic [NUM_CHUNKS*CHUNK_BITS-1:0] sent_grid,
    input  logic [CHUNK_W-1:0]               ptr,
    output logic [CHUNK_W-1:0]               idx,
    output logic                             valid
);

    logic [NUM_CHUNKS-1:0] dirty;
    logic [CHUNK_W-1:0]    hi;
    logic [CHUNK_W-1:0]    lo;
    logic                  hi_ok;

    always_comb begin
        for (int c = 0; c < NUM_CHUNKS; c++) begin
            dirty[c] = local_grid[c*CHUNK_BITS +: CHUNK_BITS]
                    != sent_grid[c*CHUNK_BITS +: CHUNK_BITS];
        end
    end

    // Scanning downward leaves the lowest match in each candidate
    always_comb begin
        hi    = '0;
        lo    = '0;
        hi_ok = 1'b0;
        for (int c = NUM_CHUNKS - 1; c >= 0; c--) begin
            if (dirty[c]) begin
                lo = CHUNK_W'(c);
                if (c >= int'(ptr)) begin
                    hi    = CHUNK_W'(c);
                    hi_ok = 1'b1;
                end
            end
        end
        valid = |dirty;
        idx   = hi_ok ? hi : lo;
    end

endmodule

// File: rtl/net_sync.sv
// net_sync: ACK-gated player/board sync engine over a 32-bit serial link.
// Define NET_BOARD_SYNC_EN to enable board chunk TX (host) and RX (others).
module net_sync
    import net_pkg::*;
#(
    parameter int NUM_PLAYERS = 4,
    parameter int GRID_CELLS  = 104,
    parameter int ACK_TIMEOUT = 2_000_000,
    parameter int MAX_RETRY   = 3
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [1:0]                          player_id,
    input  player_rec_t                         local_rec,
    input  logic [2:0]                          local_game_state,
    input  logic [GRID_CELLS*4-1:0]             local_grid,
    net_sync_if.master                          link,
    output player_rec_t [NUM_PLAYERS-1:0]       players,
    output logic [2:0]                          game_state_out,
    output logic [GRID_CELLS*4-1:0]             grid_out,
    output logic                                link_fault,
    output logic [1:0]                          tx_fsm
);

    localparam int NUM_CHUNKS = (GRID_CELLS + CELLS_PER_PKT - 1) / CELLS_PER_PKT;
    localparam int PAD_BITS   = NUM_CHUNKS * CHUNK_BITS;
    localparam int TW         = $clog2(ACK_TIMEOUT + 1);
    localparam int RW         = $clog2(MAX_RETRY + 1);

    tx_state_t   state;
    logic [TW-1:0] timer;
    logic [RW-1:0] retry;
    logic [26:0] last_sent;
    logic [26:0] fly_rec;
    logic [26:0] cur;
    logic [2:0]  gstate;
    logic        host;
    logic        ack;
    logic [2:0]  rx_type;
    logic [1:0]  rx_id;

    assign host    = player_id == 2'd0;
    assign gstate  = host ? local_game_state : 3'b000;
    assign cur     = {local_rec, gstate};
    assign rx_type = link.rx_data[2:0];
    assign rx_id   = link.rx_data[31:30];
    assign ack     = link.rx_valid && rx_type == PKT_ACK;
    assign tx_fsm  = state;

`ifdef NET_BOARD_SYNC_EN
    logic [PAD_BITS-1:0]   grid_pad;
    logic [PAD_BITS-1:0]   sent_grid;
    logic [CHUNK_W-1:0]    ptr;
    logic [CHUNK_W-1:0]    pick;
    logic                  pick_ok;
    logic [CHUNK_BITS-1:0] pick_cells;
    logic [19:0]           pick_wire;
    logic [CHUNK_W-1:0]    fly_idx;
    logic [CHUNK_BITS-1:0] fly_cells;
    logic                  fly_board;
    logic [CHUNK_W-1:0]    rx_chunk;
    logic                  board_rx;

    // Cells past GRID_CELLS are zero in both copies, so they never look dirty
    assign grid_pad   = PAD_BITS'(local_grid);
    assign pick_cells = grid_pad[int'(pick)*CHUNK_BITS +: CHUNK_BITS];
    assign rx_chunk   = link.rx_data[29:23];
    assign board_rx   = link.rx_valid && rx_type == PKT_BOARD
                     && rx_id == 2'd0 && int'(rx_chunk) < NUM_CHUNKS;

    always_comb begin
        pick_wire = '0;
        for (int k = 0; k < CELLS_PER_PKT; k++) begin
            pick_wire[19-4*k -: 4] = pick_cells[4*k +: 4];
        end
    end

    dirty_chunk_picker #(
        .NUM_CHUNKS(NUM_CHUNKS)
    ) u_pick (
        .local_grid(grid_pad),
        .sent_grid (sent_grid),
        .ptr       (ptr),
        .idx       (pick),
        .valid     (pick_ok)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= TX_IDLE;
            link.tx_data    <= '0;
            link.tx_trigger <= 1'b0;
            timer           <= '0;
            retry           <= '0;
            link_fault      <= 1'b0;
            last_sent       <= '0;
            fly_rec         <= '0;
`ifdef NET_BOARD_SYNC_EN
            sent_grid       <= '0;
            ptr             <= '0;
            fly_idx         <= '0;
            fly_cells       <= '0;
            fly_board       <= 1'b0;
`endif
        end else begin
            link.tx_trigger <= 1'b0;
            unique case (state)
                TX_IDLE: begin
                    if (cur != last_sent) begin
                        fly_rec         <= cur;
                        link.tx_data    <= pack_player(player_id, local_rec, gstate);
                        link.tx_trigger <= 1'b1;
                        state           <= TX_SEND;
`ifdef NET_BOARD_SYNC_EN
                        fly_board       <= 1'b0;
                    end else if (host && pick_ok) begin
                        fly_idx         <= pick;
                        fly_cells       <= pick_cells;
                        fly_board       <= 1'b1;
                        link.tx_data    <= pack_board(player_id, pick, pick_wire);
                        link.tx_trigger <= 1'b1;
                        state           <= TX_SEND;
`endif
                    end
                end
                TX_SEND: begin
                    if (link.tx_ready) begin
                        timer <= '0;
                        state <= TX_WAIT_ACK;
                    end
                end
                TX_WAIT_ACK: begin
                    if (ack) begin
`ifdef NET_BOARD_SYNC_EN
                        if (fly_board) begin
                            sent_grid[int'(fly_idx)*CHUNK_BITS +: CHUNK_BITS] <= fly_cells;
                            ptr <= (int'(fly_idx) == NUM_CHUNKS - 1) ? '0 : fly_idx + 1'b1;
                        end else
`endif
                        last_sent  <= fly_rec;
                        retry      <= '0;
                        link_fault <= 1'b0;
                        state      <= TX_IDLE;
                    end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
                        if (retry < RW'(MAX_RETRY)) begin
                            retry           <= retry + 1'b1;
                            link.tx_trigger <= 1'b1;
                            state           <= TX_SEND;
                        end else begin
                            state <= TX_DROP;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                TX_DROP: begin
                    link_fault <= 1'b1;
                    retry      <= '0;
                    state      <= TX_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            players        <= '0;
            game_state_out <= '0;
            grid_out       <= '0;
        end else begin
            if (link.rx_valid && rx_type == PKT_PLAYER
                && rx_id != player_id && int'(rx_id) < NUM_PLAYERS) begin
                players[rx_id] <= link.rx_data[29:6];
                if (rx_id == 2'd0) game_state_out <= link.rx_data[5:3];
            end
            // Local slot is written last so it overrides any RX write
            players[player_id] <= local_rec;
`ifdef NET_BOARD_SYNC_EN
            if (host) begin
                grid_out <= local_grid;
            end else if (board_rx) begin
                for (int k = 0; k < CELLS_PER_PKT; k++) begin
                    if (int'(rx_chunk)*CELLS_PER_PKT + k < GRID_CELLS) begin
                        grid_out[(int'(rx_chunk)*CELLS_PER_PKT + k)*4 +: 4]
                            <= link.rx_data[22-4*k -: 4];
                    end
                end
            end
`else
            grid_out <= local_grid;
`endif
        end
    end

endmodule

// File: tb/tb_net_sync.sv
// Directed bench for net_sync: a host (ID 0) and a secondary (ID 1) instance.
// Board checks run when NET_BOARD_SYNC_EN is defined, otherwise absence checks.
module tb_net_sync;
    import net_pkg::*;

    logic clk;
    logic rst;

    logic [1:0]   h_id;
    logic [1:0]   s_id;
    player_rec_t  h_rec;
    player_rec_t  s_rec;
    logic [2:0]   h_gs;
    logic [2:0]   s_gs;
    logic [415:0] h_grid;
    logic [415:0] s_grid;

    player_rec_t [3:0] h_players;
    player_rec_t [3:0] s_players;
    logic [2:0]   h_gso;
    logic [2:0]   s_gso;
    logic [415:0] h_grid_out;
    logic [415:0] s_grid_out;
    logic         h_fault;
    logic         s_fault;
    logic [1:0]   h_fsm;
    logic [1:0]   s_fsm;

    net_sync_if hb ();
    net_sync_if sb ();

    int checks;
    int failures;
    bit board_seen;

    net_sync #(
        .NUM_PLAYERS(4), .GRID_CELLS(104),
        .ACK_TIMEOUT(16), .MAX_RETRY(2)
    ) h (
        .clk(clk), .rst(rst), .player_id(h_id),
        .local_rec(h_rec), .local_game_state(h_gs),
        .local_grid(h_grid), .link(hb),
        .players(h_players), .game_state_out(h_gso),
        .grid_out(h_grid_out), .link_fault(h_fault),
        .tx_fsm(h_fsm)
    );

    net_sync #(
        .NUM_PLAYERS(4), .GRID_CELLS(104),
        .ACK_TIMEOUT(16), .MAX_RETRY(2)
    ) s (
        .clk(clk), .rst(rst), .player_id(s_id),
        .local_rec(s_rec), .local_game_state(s_gs),
        .local_grid(s_grid), .link(sb),
        .players(s_players), .game_state_out(s_gso),
        .grid_out(s_grid_out), .link_fault(s_fault),
        .tx_fsm(s_fsm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk)
        if (hb.tx_trigger && hb.tx_data[2:0] == 3'b001) board_seen = 1'b1;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, output int trig);
        trig = 0;
        repeat (n) begin
            tick();
            if (hb.tx_trigger) trig++;
        end
    endtask

    task automatic ack_h();
        hb.rx_data  = 32'h0000_0007;
        hb.rx_valid = 1'b1;
        tick();
        hb.rx_valid = 1'b0;
        hb.rx_data  = '0;
    endtask

    task automatic send_s(input logic [31:0] w);
        sb.rx_data  = w;
        sb.rx_valid = 1'b1;
        tick();
        sb.rx_valid = 1'b0;
        sb.rx_data  = '0;
    endtask

    function automatic player_rec_t mk_rec(input logic [8:0] x,
                                           input logic [8:0] y);
        player_rec_t r;
        r   = '0;
        r.x = x;
        r.y = y;
        return r;
    endfunction

    function automatic logic [31:0] ppkt(input logic [1:0] id,
                                         input logic [8:0] x,
                                         input logic [2:0] gs);
        return {id, 2'b00, x, 9'd0, 4'd0, gs, 3'b000};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int nt;
        int t2;
        int t3;
        bit same;
        logic [1:0]  fsm51;
        logic [31:0] w0;

        checks = 0;
        failures = 0;
        board_seen = 1'b0;
        rst = 1'b1;
        h_id = 2'd0;
        s_id = 2'd1;
        h_rec = '0;
        h_gs = '0;
        h_grid = '0;
        s_rec = mk_rec(9'd7, 9'd0);
        s_gs = 3'd4;
        s_grid = '0;
        s_grid[3:0] = 4'h3;
        hb.rx_data = '0;
        hb.rx_valid = 1'b0;
        hb.tx_ready = 1'b1;
        sb.rx_data = '0;
        sb.rx_valid = 1'b0;
        sb.tx_ready = 1'b1;

        tick();
        tick();
        chk("rst_fsm", 64'(h_fsm), 64'd0);
        chk("rst_trig", 64'(hb.tx_trigger), 64'd0);
        chk("rst_data", 64'(hb.tx_data), 64'd0);
        chk("rst_fault", 64'(h_fault), 64'd0);
        chk("rst_players", 64'(|s_players), 64'd0);
        chk("rst_gso", 64'(s_gso), 64'd0);
        chk("rst_grid", 64'(s_grid_out[3:0]), 64'd0);
        rst = 1'b0;
        tick();
        chk("local_slot", 64'(s_players[1].x), 64'd7);

        // host record send
        h_rec = mk_rec(9'd100, 9'd50);
        h_gs = 3'd2;
        tick();
        chk("rec_trig", 64'(hb.tx_trigger), 64'd1);
        chk("rec_id", 64'(hb.tx_data[31:30]), 64'd0);
        chk("rec_x", 64'(hb.tx_data[27:19]), 64'd100);
        chk("rec_y", 64'(hb.tx_data[18:10]), 64'd50);
        chk("rec_gs", 64'(hb.tx_data[5:3]), 64'd2);
        chk("rec_type", 64'(hb.tx_data[2:0]), 64'd0);
        chk("rec_send", 64'(h_fsm), 64'd1);
        tick();
        chk("rec_pulse1", 64'(hb.tx_trigger), 64'd0);
        chk("rec_wait", 64'(h_fsm), 64'd2);
        ack_h();
        chk("rec_idle", 64'(h_fsm), 64'd0);
        run(20, n);
        chk("rec_noresend", 64'(n), 64'd0);
        chk("host_slot", 64'(h_players[0].x), 64'd100);

        // timeout, retries, drop
        h_rec = mk_rec(9'd101, 9'd50);
        tick();
        chk("to_trig0", 64'(hb.tx_trigger), 64'd1);
        w0 = hb.tx_data;
        nt = 0;
        t2 = 0;
        t3 = 0;
        same = 1'b1;
        fsm51 = '0;
        for (int i = 1; i <= 52; i++) begin
            tick();
            if (hb.tx_trigger) begin
                nt++;
                if (nt == 1) t2 = i;
                if (nt == 2) t3 = i;
                if (hb.tx_data !== w0) same = 1'b0;
            end
            if (i == 51) fsm51 = h_fsm;
        end
        chk("to_retries", 64'(nt), 64'd2);
        chk("to_gap1", 64'(t2), 64'd17);
        chk("to_gap2", 64'(t3), 64'd34);
        chk("to_same", 64'(same), 64'd1);
        chk("to_drop", 64'(fsm51), 64'd3);
        chk("to_fault", 64'(h_fault), 64'd1);
        tick();
        chk("to_resend", 64'(hb.tx_trigger), 64'd1);
        chk("to_resend_w", 64'(hb.tx_data), 64'(w0));
        tick();
        ack_h();
        chk("to_clear", 64'(h_fault), 64'd0);

        // ACK on the timeout cycle wins
        h_rec = mk_rec(9'd102, 9'd50);
        tick();
        tick();
        repeat (15) tick();
        ack_h();
        chk("edge_idle", 64'(h_fsm), 64'd0);
        chk("edge_trig", 64'(hb.tx_trigger), 64'd0);
        run(20, n);
        chk("edge_quiet", 64'(n), 64'd0);

        // local change while in flight
        h_rec = mk_rec(9'd103, 9'd50);
        tick();
        tick();
        h_rec = mk_rec(9'd104, 9'd50);
        run(3, n);
        chk("col_trig", 64'(n), 64'd0);
        chk("col_hold", 64'(hb.tx_data[27:19]), 64'd103);
        ack_h();
        tick();
        chk("col_next", 64'(hb.tx_trigger), 64'd1);
        chk("col_next_x", 64'(hb.tx_data[27:19]), 64'd104);
        tick();
        ack_h();

        // RX merge on the secondary
        send_s(ppkt(2'd2, 9'd300, 3'd0));
        chk("rx_p2", 64'(s_players[2].x), 64'd300);
        send_s(ppkt(2'd1, 9'd5, 3'd0));
        chk("rx_self", 64'(s_players[1].x), 64'd7);
        send_s(ppkt(2'd0, 9'd9, 3'd5));
        chk("rx_gso", 64'(s_gso), 64'd5);
        chk("rx_p0", 64'(s_players[0].x), 64'd9);
        send_s(ppkt(2'd3, 9'd11, 3'd6));
        chk("rx_gso_keep", 64'(s_gso), 64'd5);
        chk("rx_p3", 64'(s_players[3].x), 64'd11);
        send_s(ppkt(2'd2, 9'd55, 3'd0) | 32'h7);
        chk("rx_ack_ign", 64'(s_players[2].x), 64'd300);

`ifdef NET_BOARD_SYNC_EN
        h_grid[3:0] = 4'hA;
        h_grid[415:412] = 4'h5;
        tick();
        chk("b0_trig", 64'(hb.tx_trigger), 64'd1);
        chk("b0_type", 64'(hb.tx_data[2:0]), 64'd1);
        chk("b0_chunk", 64'(hb.tx_data[29:23]), 64'd0);
        chk("b0_cell0", 64'(hb.tx_data[22:19]), 64'hA);
        chk("b0_rest", 64'(hb.tx_data[18:3]), 64'd0);
        send_s(hb.tx_data);
        ack_h();
        tick();
        chk("b20_trig", 64'(hb.tx_trigger), 64'd1);
        chk("b20_chunk", 64'(hb.tx_data[29:23]), 64'd20);
        chk("b20_c103", 64'(hb.tx_data[10:7]), 64'h5);
        chk("b20_rest", 64'({hb.tx_data[22:11], hb.tx_data[6:3]}), 64'd0);
        send_s(hb.tx_data);
        ack_h();
        run(20, n);
        chk("b_quiet", 64'(n), 64'd0);
        chk("b_s_c0", 64'(s_grid_out[3:0]), 64'hA);
        chk("b_s_c103", 64'(s_grid_out[415:412]), 64'h5);
        chk("b_h_c0", 64'(h_grid_out[3:0]), 64'hA);
        send_s({2'd1, 7'd0, 20'hF0000, 3'b001});
        chk("b_bad_id", 64'(s_grid_out[3:0]), 64'hA);
`else
        h_grid[3:0] = 4'hA;
        h_grid[415:412] = 4'h5;
        run(20, n);
        chk("nb_quiet", 64'(n), 64'd0);
        chk("nb_seen", 64'(board_seen), 64'd0);
        chk("nb_h_c0", 64'(h_grid_out[3:0]), 64'hA);
        send_s({2'd0, 7'd0, 20'hF0000, 3'b001});
        chk("nb_s_c0", 64'(s_grid_out[3:0]), 64'h3);
`endif

        // reset while waiting for ACK
        h_rec = mk_rec(9'd105, 9'd50);
        tick();
        tick();
        chk("rw_wait", 64'(h_fsm), 64'd2);
        rst = 1'b1;
        tick();
        chk("rw_fsm", 64'(h_fsm), 64'd0);
        chk("rw_data", 64'(hb.tx_data), 64'd0);
        chk("rw_trig", 64'(hb.tx_trigger), 64'd0);
        chk("rw_fault", 64'(h_fault), 64'd0);
        chk("rw_players", 64'(|h_players), 64'd0);
        chk("rw_grid", 64'(|h_grid_out), 64'd0);
        rst = 1'b0;
        tick();
        chk("rw_resend", 64'(hb.tx_trigger), 64'd1);
        chk("rw_resend_x", 64'(hb.tx_data[27:19]), 64'd105);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
